// File: rtl/imem_responder.sv
// imem_responder
//
// Response side of the instruction fetch path. Drives the read ports of the
// BIOS ROM and IMEM (both synchronous, 1-cycle read) from the fetch address.
// It returns the fetched instruction to decode in lockstep with the decode PC
// register. The memories re-read whenever the fetch address changes, so the
// block holds the instruction across stalls. It replaces killed or faulting
// fetches with NOP.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   if_addr            fetch address from the fetch stage
//   if_bios_en         1 = fetch from BIOS, 0 = fetch from IMEM
//   id_stall, ex_stall decode / execute stalls
//   mem_flush          redirect from the memory stage, kills the in-flight fetch
//   bios_addr/re/dout  BIOS ROM read port
//   imem_addr/re/dout  IMEM read port
//   id_inst            instruction for the current decode PC
//   id_inst_valid      id_inst is a real fetched instruction
//   id_fetch_fault     current decode instruction came from a faulting fetch
//
// state | meaning
// ------+-----------------------------------------------------------------
// EMPTY | no instruction in decode (reset or flushed), NOP with valid=0
// LIVE  | memory output belongs to decode PC, pass it through (or NOP on fault)
// HELD  | decode stalled, instruction frozen in hold_q

module imem_responder #(
    parameter int          BIOS_AW = 12,
    parameter int          IMEM_AW = 14,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        if_addr,
    input  logic               if_bios_en,
    input  logic               id_stall,
    input  logic               ex_stall,
    input  logic               mem_flush,
    output logic [BIOS_AW-1:0] bios_addr,
    output logic               bios_re,
    input  logic [31:0]        bios_dout,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_re,
    input  logic [31:0]        imem_dout,
    output logic [31:0]        id_inst,
    output logic               id_inst_valid,
    output logic               id_fetch_fault
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] LIVE  = 2'd1;
    localparam logic [1:0] HELD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        sel_q, sel_d;
    logic        fault_q, fault_d;
    logic [31:0] hold_q, hold_d;

    logic        adv;
    logic        fault;
    logic        unused_addr;

    // Same condition as the decode PC register write enable.
    assign adv   = (!id_stall && !ex_stall) || mem_flush;
    assign fault = (if_addr[1:0] != 2'b00) ||
                   (!if_bios_en && (if_addr[31:28] != 4'h1));

    assign bios_addr = if_addr[BIOS_AW+1:2];
    assign imem_addr = if_addr[IMEM_AW+1:2];
    assign bios_re   = adv && if_bios_en;
    assign imem_re   = adv && !if_bios_en;

    // Bits between the word-address field and the region nibble are unused.
    assign unused_addr = ^if_addr;

    always_comb begin
        id_inst        = NOP;
        id_inst_valid  = 1'b0;
        id_fetch_fault = 1'b0;
        case (state_q)
            LIVE: begin
                id_inst_valid  = 1'b1;
                id_fetch_fault = fault_q;
                if (!fault_q) begin
                    id_inst = sel_q ? bios_dout : imem_dout;
                end
            end
            HELD: begin
                id_inst        = hold_q;
                id_inst_valid  = 1'b1;
                id_fetch_fault = fault_q;
            end
            default: begin
                id_inst        = NOP;
                id_inst_valid  = 1'b0;
                id_fetch_fault = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        fault_d = fault_q;
        hold_d  = hold_q;
        if (mem_flush) begin
            state_d = EMPTY;
        end else if (adv) begin
            state_d = LIVE;
            sel_d   = if_bios_en;
            fault_d = fault;
        end else if (state_q == LIVE) begin
            // Freeze the memory output before the address can move on.
            state_d = HELD;
            hold_d  = id_inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            sel_q   <= 1'b0;
            fault_q <= 1'b0;
            hold_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            fault_q <= fault_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder.
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_addr;
    logic        if_bios_en;
    logic        id_stall;
    logic        ex_stall;
    logic        mem_flush;
    logic [11:0] bios_addr;
    logic        bios_re;
    logic [31:0] bios_dout;
    logic [13:0] imem_addr;
    logic        imem_re;
    logic [31:0] imem_dout;
    logic [31:0] id_inst;
    logic        id_inst_valid;
    logic        id_fetch_fault;

    int checks = 0;
    int errors = 0;

    imem_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_addr        (if_addr),
        .if_bios_en     (if_bios_en),
        .id_stall       (id_stall),
        .ex_stall       (ex_stall),
        .mem_flush      (mem_flush),
        .bios_addr      (bios_addr),
        .bios_re        (bios_re),
        .bios_dout      (bios_dout),
        .imem_addr      (imem_addr),
        .imem_re        (imem_re),
        .imem_dout      (imem_dout),
        .id_inst        (id_inst),
        .id_inst_valid  (id_inst_valid),
        .id_fetch_fault (id_fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] inst, input logic v, input logic f);
        chk({tag, ".inst"}, id_inst, inst);
        chk({tag, ".valid"}, {31'b0, id_inst_valid}, {31'b0, v});
        chk({tag, ".fault"}, {31'b0, id_fetch_fault}, {31'b0, f});
    endtask

    task automatic drive(input logic [31:0] a, input logic be, input logic ids, input logic exs,
                         input logic fl, input logic [31:0] bd, input logic [31:0] imd);
        if_addr    = a;
        if_bios_en = be;
        id_stall   = ids;
        ex_stall   = exs;
        mem_flush  = fl;
        bios_dout  = bd;
        imem_dout  = imd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset release followed by two BIOS fetches with continuous advance.
    task automatic boot_seq(input string tag);
        drive(32'h4000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
        chk_out({tag, ".c0"}, NOP, 1'b0, 1'b0);
        chk({tag, ".c0.bios_re"}, {31'b0, bios_re}, 32'd1);
        chk({tag, ".c0.imem_re"}, {31'b0, imem_re}, 32'd0);
        chk({tag, ".c0.bios_addr"}, {20'b0, bios_addr}, 32'd0);
        tick;
        drive(32'h4000_0004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0093, 32'hBBBB_BBBB);
        chk_out({tag, ".c1"}, 32'h0000_0093, 1'b1, 1'b0);
        chk({tag, ".c1.bios_re"}, {31'b0, bios_re}, 32'd1);
        chk({tag, ".c1.bios_addr"}, {20'b0, bios_addr}, 32'd1);
        tick;
        drive(32'h4000_0008, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0010_0113, 32'hBBBB_BBBB);
        chk_out({tag, ".c2"}, 32'h0010_0113, 1'b1, 1'b0);
        chk({tag, ".c2.bios_re"}, {31'b0, bios_re}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'h4000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        tick;
        chk_out("reset", NOP, 1'b0, 1'b0);
        #2 rst_n = 1'b1;

        boot_seq("boot");
        tick;

        // Stall for three cycles starting while 0x93 is live.
        drive(32'h4000_000C, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0093, 32'h0);
        chk_out("stall0", 32'h0000_0093, 1'b1, 1'b0);
        chk("stall0.bios_re", {31'b0, bios_re}, 32'd0);
        tick;
        drive(32'h4000_000C, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
        chk_out("stall1", 32'h0000_0093, 1'b1, 1'b0);
        tick;
        drive(32'h4000_000C, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
        chk_out("stall2", 32'h0000_0093, 1'b1, 1'b0);
        tick;
        // Release: still showing the held word this cycle.
        drive(32'h4000_000C, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
        chk_out("release", 32'h0000_0093, 1'b1, 1'b0);
        chk("release.bios_re", {31'b0, bios_re}, 32'd1);
        chk("release.bios_addr", {20'b0, bios_addr}, 32'd3);
        tick;
        drive(32'h4000_000C, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0020_0193, 32'h0);
        chk_out("after_rel", 32'h0020_0193, 1'b1, 1'b0);
        tick;

        // Flush together with stall from HELD.
        drive(32'h4000_000C, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0);
        chk_out("held_pre_flush", 32'h0020_0193, 1'b1, 1'b0);
        tick;
        drive(32'h1000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
        chk_out("flushed", NOP, 1'b0, 1'b0);
        chk("flushed.imem_re", {31'b0, imem_re}, 32'd1);
        chk("flushed.bios_re", {31'b0, bios_re}, 32'd0);
        chk("flushed.imem_addr", {18'b0, imem_addr}, 32'd0);
        tick;

        // Interleave IMEM and BIOS; select follows the registered select.
        drive(32'h4000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0513);
        chk_out("imem0", 32'h0000_0513, 1'b1, 1'b0);
        tick;
        drive(32'h1000_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0030_0213, 32'h0000_0613);
        chk_out("bios_sel", 32'h0030_0213, 1'b1, 1'b0);
        chk("bios_sel.imem_addr", {18'b0, imem_addr}, 32'd1);
        tick;
        drive(32'h4000_0014, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0293, 32'h0000_0713);
        chk_out("imem_sel", 32'h0000_0713, 1'b1, 1'b0);
        tick;
        drive(32'h1000_0002, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0050_0313, 32'h0000_0813);
        chk_out("bios_sel2", 32'h0050_0313, 1'b1, 1'b0);
        tick;

        // Misaligned fetch, then stall on it.
        drive(32'h1000_0002, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0060_0393, 32'h0000_0913);
        chk_out("misalign", NOP, 1'b1, 1'b1);
        tick;
        drive(32'h2000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0060_0393, 32'h0000_0913);
        chk_out("misalign_held", NOP, 1'b1, 1'b1);
        tick;
        // Bad IMEM region, stalled through ex_stall.
        drive(32'h2000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0070_0413, 32'h0000_0A13);
        chk_out("region", NOP, 1'b1, 1'b1);
        tick;
        drive(32'h1000_0008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0070_0413, 32'h0000_0A13);
        chk_out("region_held", NOP, 1'b1, 1'b1);
        tick;
        drive(32'h1000_000C, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0080_0493, 32'h0000_0B13);
        chk_out("good_imem", 32'h0000_0B13, 1'b1, 1'b0);
        tick;

        // Reset mid-stall while HELD.
        drive(32'h1000_000C, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0080_0493, 32'h0000_0C13);
        chk_out("held_pre_rst", 32'h0000_0B13, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", NOP, 1'b0, 1'b0);
        tick;
        #2 rst_n = 1'b1;
        boot_seq("reboot");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory response side of the fetch interface. Each cycle it takes the fetch address and BIOS select produced by the fetch stage and drives the read ports of the BIOS ROM and IMEM, which are synchronous with a 1-cycle read. It returns the fetched instruction to decode in lockstep with the decode-stage PC register. Because the memories re-read whenever the fetch address changes, the block holds the instruction across pipeline stalls and replaces killed or faulting fetches with a NOP.

## Interface

Parameters:
- BIOS_AW, 12, BIOS word-address width.
- IMEM_AW, 14, IMEM word-address width.
- NOP, 32'h0000_0013, instruction injected for bubbles and faults (`addi x0,x0,0`).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_addr  in  32  fetch address from the fetch stage.
- if_bios_en  in  1  1 = fetch from BIOS, 0 = fetch from IMEM.
- id_stall  in  1  decode stall.
- ex_stall  in  1  execute stall.
- mem_flush  in  1  redirect from memory stage; kills in-flight fetch.
- bios_addr  out  BIOS_AW  `if_addr[BIOS_AW+1:2]`, combinational.
- bios_re  out  1  `adv && if_bios_en`.
- bios_dout  in  32  BIOS read data, valid the cycle after the address.
- imem_addr  out  IMEM_AW  `if_addr[IMEM_AW+1:2]`, combinational.
- imem_re  out  1  `adv && !if_bios_en`.
- imem_dout  in  32  IMEM read data, valid the cycle after the address.
- id_inst  out  32  instruction for the current decode PC.
- id_inst_valid  out  1  id_inst is a real fetched instruction.
- id_fetch_fault  out  1  current decode instruction came from a faulting fetch.

## Operation

- `adv = (!id_stall && !ex_stall) || mem_flush`. This is identical to the decode PC register write enable, so the output always matches the decode PC.
- Fault condition, evaluated on the fetch address: `if_addr[1:0] != 0`, or `!if_bios_en && if_addr[31:28] != 4'h1`.
- The state machine has three states: EMPTY, LIVE and HELD.
- Registers: `sel_q` (BIOS select of the last accepted fetch), `fault_q`, and `hold_q[31:0]`.
- Transitions, evaluated at each rising edge in priority order:
  - mem_flush=1 → EMPTY. hold_q is not updated and the current fetch is discarded.
  - adv=1 → LIVE. `sel_q <= if_bios_en`, `fault_q <= fault`.
  - Stall in LIVE → HELD. `hold_q <= id_inst` (the current mux output).
  - Stall in HELD or EMPTY → no change.
- Outputs (combinational from state and registers):
  - EMPTY: id_inst=NOP, valid=0, fault=0.
  - LIVE, fault_q=0: id_inst = `sel_q ? bios_dout : imem_dout`; valid=1; fault=0.
  - LIVE, fault_q=1: id_inst=NOP, valid=1, fault=1.
  - HELD: id_inst=hold_q, valid=1, fault=fault_q.
- The read enables are deasserted during stalls. Memories may still see address changes; the block ignores their data while HELD.

## Timing

- Reset (async, rst_n=0): state=EMPTY, sel_q=0, fault_q=0, hold_q=0. Outputs take their EMPTY values immediately, without waiting for a clock edge.
- Latency: an address accepted on edge k (adv=1) produces its id_inst in the cycle after edge k, with zero added combinational delay beyond the memory output.
- First cycle after reset release: EMPTY (NOP, valid=0). The first real instruction appears in the cycle after the first adv edge.
- Stall entered from LIVE: the instruction is frozen in hold_q on the same edge. id_inst remains bit-identical for the whole stall, for any stall length.
- Stall release from HELD: the next edge loads the instruction for the new address, and the block returns to LIVE one cycle later.
- Flush together with a stall: flush wins → EMPTY for exactly one cycle (if adv on that edge). This applies from every state, including HELD.
- Back-to-back flushes: EMPTY persists while flushing; each flushed fetch is discarded.
- rst_n asserted mid-stall or mid-flush: all state clears asynchronously. There is no residual hold data after release.

## Test plan

- Reset release with BIOS at 0x4000_0000, continuous adv; `bios_dout` returns 0x0000_0093 then 0x0010_0113. Required: first cycle NOP with valid=0; then those two words in order with valid=1, one cycle after each address; bios_re high throughout.
- Stall: with id_stall high for 3 cycles starting while 0x0000_0093 is LIVE, drive bios_dout to 0xDEAD_BEEF during the stall. Required: id_inst = 0x0000_0093 for all 3 cycles, and the new instruction appears the cycle after release.
- mem_flush with id_stall, from HELD. Required: next cycle NOP with valid=0 and fault=0; next accepted fetch (IMEM 0x1000_0000, imem_dout=0x0000_0513) delivered afterwards.
- Faults:
  - Fetch of 0x1000_0002 (misaligned) → NOP, valid=1, fault=1.
  - Fetch of 0x2000_0000 with bios_en=0 → same result.
  - Stalling on either fault keeps fault=1.
- Interleave BIOS and IMEM fetches with differing dout values on both memories. Required: the mux selects by the registered select, never the current if_bios_en.
- Assert rst_n low mid-stall while HELD. Required: outputs go to NOP/0/0 before the next clock edge, and post-release behaviour matches the first test.
